// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO write- and read-side logic.
// Conversions operate on a fixed maximum width; callers zero-extend their
// pointer into PTR_MAX_W bits and truncate the result back to their width.
// Zero-extension does not disturb either conversion.
package async_fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    // Binary to reflected Gray code.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR prefix starting from the MSB.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_lvl.sv
// Write-side pointer, full / almost-full / level generation for an async FIFO.
// Optional sticky overflow flag enabled by macro ASYNC_FIFO_OVERFLOW_EN;
// without it woverflow is a constant 0 and no flop is built.
module wptr_full_lvl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDRWIDTH    = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [ADDRWIDTH:0]   wq2_rptr,
    output logic                 wfull,
    output logic                 wafull,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic [ADDRWIDTH:0]   wptr,
    output logic [ADDRWIDTH:0]   wlevel,
    output logic                 woverflow
);

    localparam int unsigned PW = ADDRWIDTH + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] wq2_rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_ptr;
    logic          wpush;
    logic          wfull_next;
    logic          wafull_next;

    // Next-pointer, synchronized read pointer decode and flag terms.
    always_comb begin
        wpush       = winc & ~wfull;
        wbinnext    = wbin + PW'(wpush);
        wgraynext   = PW'(bin2gray(PTR_MAX_W'(wbinnext)));
        wq2_rbin    = PW'(gray2bin(PTR_MAX_W'(wq2_rptr)));
        level_next  = wbinnext - wq2_rbin;
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_ptr    = {~wq2_rptr[ADDRWIDTH:ADDRWIDTH-1], wq2_rptr[ADDRWIDTH-2:0]};
        wfull_next  = (wgraynext == full_ptr);
        wafull_next = (level_next >= PW'(AFULL_THRESH));
    end

    assign waddr = wbin[ADDRWIDTH-1:0];

    // Pointer and status registers; reset overrides any pending write.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= wfull_next;
            wafull <= wafull_next;
            wlevel <= level_next;
        end
    end

`ifdef ASYNC_FIFO_OVERFLOW_EN
    // Sticky record of any write attempted while full; only reset clears it.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end
    end
`else
    assign woverflow = 1'b0;
`endif

endmodule
